// File: rtl/biu_arb_pkg.sv
// Shared encodings for the three-requester BIU arbiter: FSM states, owner
// codes, ack bit positions and burst geometry.
package biu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWN_ICU = 2'd0;
  localparam logic [1:0] OWN_DCU = 2'd1;
  localparam logic [1:0] OWN_AUX = 2'd2;

  localparam int unsigned ACK_NORMAL  = 0;
  localparam int unsigned ACK_ERR     = 1;
  localparam int unsigned BURST_BEATS = 4;
  localparam int unsigned BURST_BIT   = 3;

  // Beats still owed once the address-phase ack of a burst has been taken.
  localparam logic [1:0] BEATS_AFTER_ADDR = 2'(BURST_BEATS - 1);

endpackage

// File: rtl/biu_rr_pick.sv
// Combinational 3-way round-robin picker; the search starts at the requester
// after last_i in the fixed order ICU, DCU, AUX.
module biu_rr_pick
  import biu_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [2:0] gnt_o,
  output logic [1:0] win_o
);

  int unsigned start;
  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_o = '0;
    win_o = OWN_ICU;
    found = 1'b0;
    idx   = 0;
    // Unused code 3 behaves like AUX so ICU is tried first.
    if (last_i == OWN_ICU)      start = 1;
    else if (last_i == OWN_DCU) start = 2;
    else                        start = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      idx = start + k;
      if (idx >= 3) idx = idx - 3;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/biu_arb3.sv
// Three-requester bus arbiter and transaction sequencer for the picoJava
// external bus: round-robin grant, single/burst tracking, ack steering, watchdog.
module biu_arb3
  import biu_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       icu_req,
  input  logic       dcu_req,
  input  logic       aux_req,
  input  logic [3:0] icu_type,
  input  logic [3:0] dcu_type,
  input  logic [3:0] aux_type,
  input  logic [1:0] icu_size,
  input  logic [1:0] dcu_size,
  input  logic [1:0] aux_size,
  output logic [1:0] biu_icu_ack,
  output logic [1:0] biu_dcu_ack,
  output logic [1:0] biu_aux_ack,
  output logic       pj_tv,
  output logic       pj_ale,
  output logic [3:0] pj_type,
  output logic [1:0] pj_size,
  input  logic [1:0] pj_ack,
  output logic [1:0] arb_owner,
  output logic       arb_timeout
);

  arb_state_e      state_q;
  logic [1:0]      owner_q;
  logic [1:0]      last_q;
  logic [1:0]      beats_q;
  logic [3:0]      type_q;
  logic [1:0]      size_q;
  logic [TO_W-1:0] wd_q;

  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] win;
  logic       any_req;
  logic       busy;
  logic       fire;
  logic [3:0] win_type;
  logic [1:0] win_size;
  logic [1:0] own_ack;

  assign req     = {aux_req, dcu_req, icu_req};
  assign any_req = |req;
  assign busy    = (state_q != ST_IDLE);
  assign fire    = busy && (pj_ack == 2'b00) && (wd_q == TO_W'(TIMEOUT));

  biu_rr_pick u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt),
    .win_o  (win)
  );

  assign win_type = ({4{gnt[0]}} & icu_type) | ({4{gnt[1]}} & dcu_type)
                  | ({4{gnt[2]}} & aux_type);
  assign win_size = ({2{gnt[0]}} & icu_size) | ({2{gnt[1]}} & dcu_size)
                  | ({2{gnt[2]}} & aux_size);

  always_comb begin
    pj_tv       = 1'b0;
    pj_ale      = 1'b1;
    pj_type     = type_q;
    pj_size     = size_q;
    arb_owner   = owner_q;
    own_ack     = '0;
    arb_timeout = 1'b0;
    if (reset) begin
      pj_type   = '0;
      pj_size   = '0;
      arb_owner = OWN_ICU;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pj_tv  = any_req;
          pj_ale = ~any_req;
          if (any_req) begin
            pj_type   = win_type;
            pj_size   = win_size;
            arb_owner = win;
          end
        end
        ST_ADDR, ST_DATA: begin
          pj_tv       = (state_q == ST_ADDR);
          own_ack     = fire ? 2'b10 : pj_ack;
          arb_timeout = fire;
        end
        default: ;
      endcase
    end
  end

  assign biu_icu_ack = (owner_q == OWN_ICU) ? own_ack : 2'b00;
  assign biu_dcu_ack = (owner_q == OWN_DCU) ? own_ack : 2'b00;
  assign biu_aux_ack = (owner_q == OWN_AUX) ? own_ack : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_ICU;
      last_q  <= OWN_AUX;
      beats_q <= '0;
      type_q  <= '0;
      size_q  <= '0;
      wd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q <= win;
            last_q  <= win;
            type_q  <= win_type;
            size_q  <= win_size;
            wd_q    <= '0;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (pj_ack != 2'b00) begin
            wd_q <= '0;
            if (pj_ack[ACK_ERR]) begin
              state_q <= ST_IDLE;
            end else if (state_q == ST_ADDR) begin
              if (type_q[BURST_BIT]) begin
                state_q <= ST_DATA;
                beats_q <= BEATS_AFTER_ADDR;
              end else begin
                state_q <= ST_IDLE;
              end
            end else if (beats_q == 2'd1) begin
              beats_q <= '0;
              state_q <= ST_IDLE;
            end else begin
              beats_q <= beats_q - 2'd1;
            end
          end else if (fire) begin
            state_q <= ST_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biu_arb3.sv
// Directed bench for biu_arb3 with a transaction-level reference model checked
// every cycle, plus literal per-scenario expectations.
module tb_biu_arb3;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       icu_req = 1'b0, dcu_req = 1'b0, aux_req = 1'b0;
  logic [3:0] icu_type = '0, dcu_type = '0, aux_type = '0;
  logic [1:0] icu_size = '0, dcu_size = '0, aux_size = '0;
  logic [1:0] pj_ack = '0;
  logic [1:0] biu_icu_ack, biu_dcu_ack, biu_aux_ack;
  logic       pj_tv, pj_ale, arb_timeout;
  logic [3:0] pj_type;
  logic [1:0] pj_size, arb_owner;

  always #5 clk = ~clk;

  biu_arb3 #(.TIMEOUT(TO), .TO_W(3)) dut (
    .clk(clk), .reset(reset),
    .icu_req(icu_req), .dcu_req(dcu_req), .aux_req(aux_req),
    .icu_type(icu_type), .dcu_type(dcu_type), .aux_type(aux_type),
    .icu_size(icu_size), .dcu_size(dcu_size), .aux_size(aux_size),
    .biu_icu_ack(biu_icu_ack), .biu_dcu_ack(biu_dcu_ack), .biu_aux_ack(biu_aux_ack),
    .pj_tv(pj_tv), .pj_ale(pj_ale), .pj_type(pj_type), .pj_size(pj_size),
    .pj_ack(pj_ack), .arb_owner(arb_owner), .arb_timeout(arb_timeout)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observed-event counters for scenario-level literal checks.
  int cnt_tv, cnt_ale_lo, cnt_to;
  int cnt_ok[3];
  int cnt_err[3];
  int gq[$];

  task automatic clear_counts();
    cnt_tv = 0; cnt_ale_lo = 0; cnt_to = 0;
    for (int i = 0; i < 3; i++) begin cnt_ok[i] = 0; cnt_err[i] = 0; end
    gq.delete();
  endtask

  // Reference model: transaction view (busy, in-address-phase, normal acks
  // still owed, cycles since grant or last ack).
  bit m_busy = 0, m_addr = 0;
  int m_left = 0, m_owner = 0, m_last = 2, m_stall = 0, m_type = 0, m_size = 0;

  always @(negedge clk) begin
    int r[3]; int ty[3]; int sz[3]; int e_ack[3]; int a[3];
    int ack, win, e_tv, e_ale, e_ty, e_sz, e_own, e_to;
    bit fire;
    r   = '{int'(icu_req), int'(dcu_req), int'(aux_req)};
    ty  = '{int'(icu_type), int'(dcu_type), int'(aux_type)};
    sz  = '{int'(icu_size), int'(dcu_size), int'(aux_size)};
    a   = '{int'(biu_icu_ack), int'(biu_dcu_ack), int'(biu_aux_ack)};
    ack = int'(pj_ack);
    e_ack = '{0, 0, 0};
    e_to = 0; e_own = -1; win = -1; fire = 0;
    if (reset) begin
      e_tv = 0; e_ale = 1; e_ty = 0; e_sz = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= 3; k++)
        if (win < 0 && r[(m_last + k) % 3] != 0) win = (m_last + k) % 3;
      e_tv = (win >= 0); e_ale = (win < 0);
      if (win >= 0) begin e_ty = ty[win]; e_sz = sz[win]; e_own = win; end
      else begin e_ty = m_type; e_sz = m_size; e_own = m_owner; end
    end else begin
      fire = (ack == 0 && m_stall == TO);
      e_tv = m_addr; e_ale = 1; e_ty = m_type; e_sz = m_size; e_own = m_owner;
      e_ack[m_owner] = fire ? 2 : ack;
      e_to = fire;
    end

    check("pj_tv", pj_tv, e_tv);
    check("pj_ale", pj_ale, e_ale);
    check("pj_type", pj_type, e_ty);
    check("pj_size", pj_size, e_sz);
    if (e_own >= 0) check("arb_owner", arb_owner, e_own);
    check("icu_ack", a[0], e_ack[0]);
    check("dcu_ack", a[1], e_ack[1]);
    check("aux_ack", a[2], e_ack[2]);
    check("arb_timeout", arb_timeout, e_to);

    if (!reset) begin
      cnt_tv += int'(pj_tv);
      if (!pj_ale) cnt_ale_lo++;
      if (pj_tv && !pj_ale) gq.push_back(int'(arb_owner));
      cnt_to += int'(arb_timeout);
      for (int i = 0; i < 3; i++) begin
        if (a[i] == 1) cnt_ok[i]++;
        if (a[i] >= 2) cnt_err[i]++;
      end
    end

    if (reset) begin
      m_busy = 0; m_addr = 0; m_left = 0; m_owner = 0; m_last = 2;
      m_stall = 0; m_type = 0; m_size = 0;
    end else if (!m_busy) begin
      if (win >= 0) begin
        m_busy = 1; m_addr = 1; m_owner = win; m_last = win;
        m_type = ty[win]; m_size = sz[win]; m_stall = 0;
        m_left = (ty[win] >= 8) ? 4 : 1;
      end
    end else if (ack != 0) begin
      m_stall = 0;
      if (ack >= 2) m_busy = 0;
      else begin
        m_left--; m_addr = 0;
        if (m_left == 0) m_busy = 0;
      end
    end else if (fire) begin
      m_busy = 0;
    end else if (m_stall < TO) begin
      m_stall++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ack_pulse(input int gap, input logic [1:0] v);
    repeat (gap) step();
    pj_ack = v;
    step();
    pj_ack = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    clear_counts();
    @(negedge clk);
    check("reset_tv", pj_tv, 0);
    check("reset_ale", pj_ale, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ICU single read, ack two cycles after the address phase starts.
    clear_counts();
    icu_req = 1; icu_type = 4'b0000; icu_size = 2'b10;
    step();
    ack_pulse(1, 2'b01);
    icu_req = 0;
    repeat (2) step();
    check("t1_tv_cycles", cnt_tv, 3);
    check("t1_icu_ok", cnt_ok[0], 1);
    check("t1_dcu_ok", cnt_ok[1], 0);

    // DCU burst, 2-cycle gap before the third beat.
    clear_counts();
    dcu_req = 1; dcu_type = 4'b1000; dcu_size = 2'b11;
    step();
    ack_pulse(0, 2'b01);
    dcu_req = 0;
    ack_pulse(0, 2'b01);
    ack_pulse(2, 2'b01);
    ack_pulse(0, 2'b01);
    repeat (2) step();
    check("t2_dcu_ok", cnt_ok[1], 4);
    check("t2_tv_cycles", cnt_tv, 2);

    // All three requesting continuously from reset.
    reset = 1;
    icu_req = 1; dcu_req = 1; aux_req = 1;
    icu_type = 4'b0001; dcu_type = 4'b0010; aux_type = 4'b0100;
    icu_size = 2'b00; dcu_size = 2'b01; aux_size = 2'b10;
    repeat (2) step();
    reset = 0;
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      step();
      ack_pulse(0, 2'b01);
    end
    icu_req = 0; dcu_req = 0; aux_req = 0;
    step();
    check("t3_grants", gq.size(), 4);
    if (gq.size() == 4) begin
      check("t3_g0", gq[0], 0);
      check("t3_g1", gq[1], 1);
      check("t3_g2", gq[2], 2);
      check("t3_g3", gq[3], 0);
    end
    check("t3_ale_lo", cnt_ale_lo, 4);

    // AUX burst with error on beat 2, then a normal ICU single.
    clear_counts();
    aux_req = 1; aux_type = 4'b1001; aux_size = 2'b01;
    step();
    ack_pulse(0, 2'b01);
    aux_req = 0;
    ack_pulse(0, 2'b10);
    check("t4_aux_ok", cnt_ok[2], 1);
    check("t4_aux_err", cnt_err[2], 1);
    icu_req = 1; icu_type = 4'b0000; icu_size = 2'b11;
    step();
    ack_pulse(0, 2'b01);
    icu_req = 0;
    step();
    check("t4_icu_ok", cnt_ok[0], 1);

    // Ack 2'b11 on a burst address phase counts as an error.
    clear_counts();
    dcu_req = 1; dcu_type = 4'b1010; dcu_size = 2'b00;
    step();
    ack_pulse(0, 2'b11);
    dcu_req = 0;
    step();
    check("t4b_dcu_err", cnt_err[1], 1);

    // Watchdog abort with no ack at all.
    clear_counts();
    dcu_req = 1; dcu_type = 4'b0000; dcu_size = 2'b01;
    step();
    repeat (4) step();
    dcu_req = 0;
    repeat (2) step();
    check("t5_timeout", cnt_to, 1);
    check("t5_dcu_err", cnt_err[1], 1);
    check("t5_tv_cycles", cnt_tv, 6);

    // Reset in DATA with two beats left.
    dcu_req = 1; dcu_type = 4'b1000; dcu_size = 2'b10;
    step();
    ack_pulse(0, 2'b01);
    dcu_req = 0;
    ack_pulse(0, 2'b01);
    reset = 1; icu_req = 1; aux_req = 1;
    icu_type = 4'b0011; aux_type = 4'b0101;
    clear_counts();
    repeat (2) step();
    reset = 0;
    @(negedge clk);
    check("t6_owner_after_reset", arb_owner, 0);
    check("t6_tv_after_reset", pj_tv, 1);
    @(posedge clk); #1;
    ack_pulse(0, 2'b01);
    icu_req = 0;
    step();
    ack_pulse(0, 2'b01);
    aux_req = 0;
    repeat (2) step();
    check("t6_dcu_stray", cnt_ok[1] + cnt_err[1], 0);
    check("t6_icu_ok", cnt_ok[0], 1);
    check("t6_aux_ok", cnt_ok[2], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
